// File: rtl/hdmi_tx_pkg.sv
// Shared definitions for the 720x480p60 (VIC 3) HDMI/DVI transmitter core:
// raster constants, TMDS control/clock symbols and the RGB colour type.
package hdmi_tx_pkg;

  localparam int H_ACTIVE = 720;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 62;
  localparam int H_BACK   = 60;
  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 9;
  localparam int V_SYNC   = 6;
  localparam int V_BACK   = 30;

  localparam logic [9:0] CTRL_00      = 10'b1101010100;
  localparam logic [9:0] CTRL_01      = 10'b0010101011;
  localparam logic [9:0] CTRL_10      = 10'b0101010100;
  localparam logic [9:0] CTRL_11      = 10'b1010101011;
  localparam logic [9:0] CLOCK_SYMBOL = 10'b1111100000;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } colour_t;

  function automatic logic [9:0] control_symbol(input logic [1:0] c);
    case (c)
      2'b00:   return CTRL_00;
      2'b01:   return CTRL_01;
      2'b10:   return CTRL_10;
      default: return CTRL_11;
    endcase
  endfunction

  // Eight 90-pixel colour bars across the active width.
  function automatic colour_t bar_colour(input logic signed [11:0] x);
    if (x < 12'sd90)       return '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
    else if (x < 12'sd180) return '{r: 8'hFF, g: 8'hFF, b: 8'h00};
    else if (x < 12'sd270) return '{r: 8'h00, g: 8'hFF, b: 8'hFF};
    else if (x < 12'sd360) return '{r: 8'h00, g: 8'hFF, b: 8'h00};
    else if (x < 12'sd450) return '{r: 8'hFF, g: 8'h00, b: 8'hFF};
    else if (x < 12'sd540) return '{r: 8'hFF, g: 8'h00, b: 8'h00};
    else if (x < 12'sd630) return '{r: 8'h00, g: 8'h00, b: 8'hFF};
    else                   return '{r: 8'h00, g: 8'h00, b: 8'h00};
  endfunction

endpackage

// File: rtl/tmds_encoder_8b10b.sv
// One DVI 1.0 TMDS channel encoder: 8b/10b data symbols with running
// disparity while de is high, control symbols (disparity cleared) otherwise.
module tmds_encoder_8b10b
  import hdmi_tx_pkg::*;
#(
  parameter logic [1:0] RESET_C = 2'b00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       de,
  input  logic [1:0] c,
  input  logic [7:0] d,
  output logic [9:0] q
);

  logic [3:0]        ones_d;
  logic [3:0]        ones_qm;
  logic              use_xnor;
  logic              chain;
  logic [8:0]        q_m;
  logic signed [4:0] balance;
  logic signed [4:0] disparity;
  logic signed [4:0] disparity_next;
  logic [9:0]        data_sym;

  // balance is ones minus zeros of q_m[7:0]; disparity tracks the same
  // quantity summed over every transmitted 10-bit symbol.
  always_comb begin
    ones_d = '0;
    for (int i = 0; i < 8; i++) ones_d = ones_d + 4'(d[i]);
    use_xnor = (ones_d > 4'd4) || ((ones_d == 4'd4) && !d[0]);
    chain = d[0];
    q_m = '0;
    q_m[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      chain = use_xnor ? ~(chain ^ d[i]) : (chain ^ d[i]);
      q_m[i] = chain;
    end
    q_m[8] = ~use_xnor;
    ones_qm = '0;
    for (int i = 0; i < 8; i++) ones_qm = ones_qm + 4'(q_m[i]);
    balance = $signed({ones_qm, 1'b0}) - 5'sd8;
    data_sym = '0;
    disparity_next = disparity;
    if ((disparity == 5'sd0) || (balance == 5'sd0)) begin
      data_sym = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
      disparity_next = q_m[8] ? (disparity + balance) : (disparity - balance);
    end else if ((!disparity[4] && (balance > 5'sd0)) ||
                 (disparity[4] && (balance < 5'sd0))) begin
      data_sym = {1'b1, q_m[8], ~q_m[7:0]};
      disparity_next = disparity + (q_m[8] ? 5'sd2 : 5'sd0) - balance;
    end else begin
      data_sym = {1'b0, q_m[8], q_m[7:0]};
      disparity_next = disparity - (q_m[8] ? 5'sd0 : 5'sd2) + balance;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q         <= control_symbol(RESET_C);
      disparity <= '0;
    end else if (de) begin
      q         <= data_sym;
      disparity <= disparity_next;
    end else begin
      q         <= control_symbol(c);
      disparity <= '0;
    end
  end

endmodule

// File: rtl/hdmi_tx_core.sv
// 720x480p60 raster generator plus three-channel TMDS encode pipeline.
// Optional colour-bar source is enabled by defining HDMI_TX_TEST_PATTERN_EN.
module hdmi_tx_core
  import hdmi_tx_pkg::*;
#(
  parameter int H_ACTIVE = hdmi_tx_pkg::H_ACTIVE,
  parameter int H_FRONT  = hdmi_tx_pkg::H_FRONT,
  parameter int H_SYNC   = hdmi_tx_pkg::H_SYNC,
  parameter int H_BACK   = hdmi_tx_pkg::H_BACK,
  parameter int V_ACTIVE = hdmi_tx_pkg::V_ACTIVE,
  parameter int V_FRONT  = hdmi_tx_pkg::V_FRONT,
  parameter int V_SYNC   = hdmi_tx_pkg::V_SYNC,
  parameter int V_BACK   = hdmi_tx_pkg::V_BACK,
  parameter bit SYNC_NEG = 1'b1
) (
  input  logic               pixelClock,
  input  logic               reset,
  input  logic [7:0]         redByte,
  input  logic [7:0]         greenByte,
  input  logic [7:0]         blueByte,
`ifdef HDMI_TX_TEST_PATTERN_EN
  input  logic               patternEnable,
`endif
  output logic signed [11:0] hPosCounter,
  output logic signed [10:0] vPosCounter,
  output logic               inActiveDisplay,
  output logic               hSync,
  output logic               vSync,
  output logic [9:0]         tmdsSymbol0,
  output logic [9:0]         tmdsSymbol1,
  output logic [9:0]         tmdsSymbol2,
  output logic [9:0]         tmdsClockSymbol
);

  localparam logic signed [11:0] H_START    = 12'(-(H_FRONT + H_SYNC + H_BACK));
  localparam logic signed [11:0] H_SYNC_LO  = 12'(-(H_SYNC + H_BACK));
  localparam logic signed [11:0] H_SYNC_HI  = 12'(-H_BACK - 1);
  localparam logic signed [11:0] H_LAST     = 12'(H_ACTIVE - 1);
  localparam logic signed [10:0] V_START    = 11'(-(V_FRONT + V_SYNC + V_BACK));
  localparam logic signed [10:0] V_SYNC_LO  = 11'(-(V_SYNC + V_BACK));
  localparam logic signed [10:0] V_SYNC_HI  = 11'(-V_BACK - 1);
  localparam logic signed [10:0] V_LAST     = 11'(V_ACTIVE - 1);

  logic    de_a;
  logic    hsync_a;
  logic    vsync_a;
  logic    c0;
  logic    c1;
  colour_t pixel;

  always_ff @(posedge pixelClock or posedge reset) begin
    if (reset) begin
      hPosCounter <= H_START;
      vPosCounter <= V_START;
    end else if (hPosCounter == H_LAST) begin
      hPosCounter <= H_START;
      vPosCounter <= (vPosCounter == V_LAST) ? V_START : vPosCounter + 11'sd1;
    end else begin
      hPosCounter <= hPosCounter + 12'sd1;
    end
  end

  assign hSync           = (hPosCounter >= H_SYNC_LO) && (hPosCounter <= H_SYNC_HI);
  assign vSync           = (vPosCounter >= V_SYNC_LO) && (vPosCounter <= V_SYNC_HI);
  assign inActiveDisplay = !hPosCounter[11] && !vPosCounter[10];
  assign tmdsClockSymbol = CLOCK_SYMBOL;

  // Stage A: delay the raster decodes one cycle to meet the returned RGB.
  always_ff @(posedge pixelClock or posedge reset) begin
    if (reset) begin
      de_a    <= 1'b0;
      hsync_a <= 1'b0;
      vsync_a <= 1'b0;
    end else begin
      de_a    <= inActiveDisplay;
      hsync_a <= hSync;
      vsync_a <= vSync;
    end
  end

`ifdef HDMI_TX_TEST_PATTERN_EN
  logic    pattern_sel_a;
  colour_t pattern_a;

  always_ff @(posedge pixelClock or posedge reset) begin
    if (reset) begin
      pattern_sel_a <= 1'b0;
      pattern_a     <= '0;
    end else begin
      pattern_sel_a <= patternEnable;
      pattern_a     <= bar_colour(hPosCounter);
    end
  end

  assign pixel = pattern_sel_a ? pattern_a : '{r: redByte, g: greenByte, b: blueByte};
`else
  assign pixel = '{r: redByte, g: greenByte, b: blueByte};
`endif

  assign c0 = hsync_a ^ SYNC_NEG;
  assign c1 = vsync_a ^ SYNC_NEG;

  // Channel 0 control pair is keyed {c0,c1}, so hsync-only sends 0010101011.
  tmds_encoder_8b10b #(.RESET_C({SYNC_NEG, SYNC_NEG})) u_enc_blue (
    .clk   (pixelClock),
    .reset (reset),
    .de    (de_a),
    .c     ({c0, c1}),
    .d     (pixel.b),
    .q     (tmdsSymbol0)
  );

  tmds_encoder_8b10b #(.RESET_C(2'b00)) u_enc_green (
    .clk   (pixelClock),
    .reset (reset),
    .de    (de_a),
    .c     (2'b00),
    .d     (pixel.g),
    .q     (tmdsSymbol1)
  );

  tmds_encoder_8b10b #(.RESET_C(2'b00)) u_enc_red (
    .clk   (pixelClock),
    .reset (reset),
    .de    (de_a),
    .c     (2'b00),
    .d     (pixel.r),
    .q     (tmdsSymbol2)
  );

endmodule

// File: tb/tb_hdmi_tx_core.sv
// Directed self-checking bench for hdmi_tx_core: reset, raster timing,
// sync symbols, TMDS data encoding/disparity, optional colour bars.
module tb_hdmi_tx_core;

  logic               pixelClock = 1'b0;
  logic               reset;
  logic [7:0]         redByte;
  logic [7:0]         greenByte;
  logic [7:0]         blueByte;
  logic               patternEnable;
  logic signed [11:0] hPosCounter;
  logic signed [10:0] vPosCounter;
  logic               inActiveDisplay;
  logic               hSync;
  logic               vSync;
  logic [9:0]         tmdsSymbol0;
  logic [9:0]         tmdsSymbol1;
  logic [9:0]         tmdsSymbol2;
  logic [9:0]         tmdsClockSymbol;

  int checkCount = 0;
  int passCount  = 0;

  logic [7:0] driven [0:719][0:2];
  int         sums [0:2];

  always #5 pixelClock = ~pixelClock;

  hdmi_tx_core dut (
    .pixelClock      (pixelClock),
    .reset           (reset),
    .redByte         (redByte),
    .greenByte       (greenByte),
    .blueByte        (blueByte),
`ifdef HDMI_TX_TEST_PATTERN_EN
    .patternEnable   (patternEnable),
`endif
    .hPosCounter     (hPosCounter),
    .vPosCounter     (vPosCounter),
    .inActiveDisplay (inActiveDisplay),
    .hSync           (hSync),
    .vSync           (vSync),
    .tmdsSymbol0     (tmdsSymbol0),
    .tmdsSymbol1     (tmdsSymbol1),
    .tmdsSymbol2     (tmdsSymbol2),
    .tmdsClockSymbol (tmdsClockSymbol)
  );

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)",
                  tag, observed, observed, expected, expected);
  endtask

  task automatic applyStimulus(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    redByte   = r;
    greenByte = g;
    blueByte  = b;
  endtask

  task automatic waitFor(input string tag, input int h, input int v, input int budget,
                         output int cycles);
    cycles = 0;
    while (!(hPosCounter == h && vPosCounter == v) && cycles < budget) begin
      @(negedge pixelClock);
      cycles++;
    end
    if (!(hPosCounter == h && vPosCounter == v)) checkOutput({tag, "_timeout"}, 0, 1);
  endtask

  function automatic logic [9:0] symbolOf(input int ch);
    return (ch == 0) ? tmdsSymbol0 : (ch == 1) ? tmdsSymbol1 : tmdsSymbol2;
  endfunction

  function automatic logic [7:0] tmdsDecode(input logic [9:0] s);
    logic [7:0] m;
    logic [7:0] d;
    m = s[9] ? ~s[7:0] : s[7:0];
    d[0] = m[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (m[i] ^ m[i-1]) : ~(m[i] ^ m[i-1]);
    return d;
  endfunction

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int hsCount, deCount, vsCount, firstHs, lastHs, firstVs;
    int maxAbs, decodeErrs, pObs, pDrv, bal;
    logic [7:0] bytes [0:2];
    logic [9:0] s;

    reset = 1'b1;
    patternEnable = 1'b0;
    applyStimulus(8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge pixelClock);
    reset = 1'b0;
    repeat (200) @(negedge pixelClock);

    // Reset asserted mid-line acts immediately
    #2 reset = 1'b1;
    #1;
    checkOutput("rstHPos", hPosCounter, -138);
    checkOutput("rstVPos", vPosCounter, -45);
    checkOutput("rstSym0", tmdsSymbol0, 10'b1010101011);
    checkOutput("rstSym1", tmdsSymbol1, 10'b1101010100);
    checkOutput("rstSym2", tmdsSymbol2, 10'b1101010100);
    checkOutput("clockSym", tmdsClockSymbol, 10'b1111100000);
    checkOutput("rstSyncDe", {hSync, vSync, inActiveDisplay}, 0);
    @(negedge pixelClock);
    reset = 1'b0;
    @(negedge pixelClock);
    checkOutput("releaseHPos", hPosCounter, -137);
    checkOutput("releaseVPos", vPosCounter, -45);

    waitFor("lineLen", -138, -44, 2000, n);
    checkOutput("lineLength", n, 857);

    // One front-porch line: hsync window and channel-0 symbol edges
    hsCount = 0; deCount = 0; vsCount = 0; firstHs = 9999; lastHs = 9999;
    for (int i = 0; i < 858; i++) begin
      if (hSync) begin
        hsCount++;
        if (firstHs == 9999) firstHs = hPosCounter;
        lastHs = hPosCounter;
      end
      if (inActiveDisplay) deCount++;
      if (vSync) vsCount++;
      if (hPosCounter == -121) checkOutput("preHsCh0", tmdsSymbol0, 10'b1010101011);
      if (hPosCounter == -120) checkOutput("hsFirstCh0", tmdsSymbol0, 10'b0010101011);
      if (hPosCounter == -59)  checkOutput("hsLastCh0", tmdsSymbol0, 10'b0010101011);
      if (hPosCounter == -58)  checkOutput("postHsCh0", tmdsSymbol0, 10'b1010101011);
      if (hPosCounter == -100) checkOutput("blankCh1", tmdsSymbol1, 10'b1101010100);
      @(negedge pixelClock);
    end
    checkOutput("hsyncWidth", hsCount, 62);
    checkOutput("hsyncFirst", firstHs, -122);
    checkOutput("hsyncLast", lastHs, -61);
    checkOutput("blankLineDe", deCount, 0);
    checkOutput("fpLineVsync", vsCount, 0);

    // Lines -43..-31 span the whole vertical sync pulse
    vsCount = 0; firstVs = 9999;
    for (int i = 0; i < 13 * 858; i++) begin
      if (vSync) begin
        vsCount++;
        if (firstVs == 9999) firstVs = vPosCounter;
      end
      if (vPosCounter == -34 && hPosCounter == -98)
        checkOutput("vsHsCh0", tmdsSymbol0, 10'b1101010100);
      if (vPosCounter == -34 && hPosCounter == -50)
        checkOutput("vsOnlyCh0", tmdsSymbol0, 10'b0101010100);
      @(negedge pixelClock);
    end
    checkOutput("vsyncWidth", vsCount, 6 * 858);
    checkOutput("vsyncFirstLine", firstVs, -36);

    waitFor("toActive", 0, 0, 30000, n);
    checkOutput("cyclesToActive", n, 30 * 858 + 138);
    checkOutput("deAtOrigin", inActiveDisplay, 1);

    // Line 0: FF, 00, 00 then random bytes; tail forces negative disparity
    deCount = 1; maxAbs = 0; decodeErrs = 0;
    for (int ch = 0; ch < 3; ch++) sums[ch] = 0;
    for (int k = 1; k <= 721; k++) begin
      @(negedge pixelClock);
      if (inActiveDisplay) deCount++;
      if (k == 1) checkOutput("preActiveCh1", tmdsSymbol1, 10'b1101010100);
      pObs = k - 2;
      if (pObs >= 0 && pObs <= 719) begin
        for (int ch = 0; ch < 3; ch++) begin
          s = symbolOf(ch);
          if (tmdsDecode(s) !== driven[pObs][ch]) decodeErrs++;
          bal = 2 * $countones(s) - 10;
          sums[ch] = sums[ch] + bal;
          if (sums[ch] > maxAbs) maxAbs = sums[ch];
          if (-sums[ch] > maxAbs) maxAbs = -sums[ch];
        end
        if (pObs == 0) checkOutput("ffFirstSym", {tmdsSymbol2, tmdsSymbol1, tmdsSymbol0},
                                   {10'h200, 10'h200, 10'h200});
        if (pObs == 1) checkOutput("zeroAfterFf", {tmdsSymbol2, tmdsSymbol1, tmdsSymbol0},
                                   {10'h3FF, 10'h3FF, 10'h3FF});
        if (pObs == 2) checkOutput("zeroThird", {tmdsSymbol2, tmdsSymbol1, tmdsSymbol0},
                                   {10'h100, 10'h100, 10'h100});
      end
      pDrv = k - 1;
      if (pDrv <= 719) begin
        for (int ch = 0; ch < 3; ch++) begin
          if (pDrv == 0) bytes[ch] = 8'hFF;
          else if (pDrv <= 2) bytes[ch] = 8'h00;
          else if (pDrv < 718) bytes[ch] = 8'($urandom_range(0, 255));
          else bytes[ch] = (sums[ch] >= 0) ? 8'h00 : 8'h11;
          driven[pDrv][ch] = bytes[ch];
        end
        applyStimulus(bytes[2], bytes[1], bytes[0]);
      end
    end
    checkOutput("activeDeCount", deCount, 720);
    checkOutput("decodeErrors", decodeErrs, 0);
    checkOutput("disparityBound", (maxAbs <= 10) ? 1 : 0, 1);

    waitFor("line1Hs", -98, 1, 200, n);
    checkOutput("hsOnlyActiveLine", tmdsSymbol0, 10'b0010101011);

    // Line 1 starts with zero disparity despite line 0 ending negative
    waitFor("line1Px", 1, 1, 300, n);
    applyStimulus(8'h00, 8'h00, 8'h00);
    @(negedge pixelClock);
    checkOutput("blankClearsDisparity", {tmdsSymbol2, tmdsSymbol1, tmdsSymbol0},
                {10'h100, 10'h100, 10'h100});
    applyStimulus(8'hFF, 8'hFF, 8'hFF);
    @(negedge pixelClock);
    checkOutput("ffAfterZero", {tmdsSymbol2, tmdsSymbol1, tmdsSymbol0},
                {10'h0FF, 10'h0FF, 10'h0FF});

`ifdef HDMI_TX_TEST_PATTERN_EN
    waitFor("line2", -138, 2, 1000, n);
    patternEnable = 1'b1;
    applyStimulus(8'h5A, 8'hA5, 8'h3C);
    waitFor("barWhite", 2, 2, 200, n);
    checkOutput("barWhiteSym", {tmdsSymbol2, tmdsSymbol1, tmdsSymbol0},
                {10'h200, 10'h200, 10'h200});
    waitFor("barYellow", 92, 2, 200, n);
    checkOutput("barYellow", {tmdsDecode(tmdsSymbol2), tmdsDecode(tmdsSymbol1),
                              tmdsDecode(tmdsSymbol0)}, 24'hFFFF00);
    waitFor("barBlack", 632, 2, 700, n);
    checkOutput("barBlack", {tmdsDecode(tmdsSymbol2), tmdsDecode(tmdsSymbol1),
                             tmdsDecode(tmdsSymbol0)}, 24'h000000);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
